// File: rtl/agu_radix_param.sv
`default_nettype none
// ============================================================================
// Module      : agu_radix_param
// Description : Parametrised address generation unit for the NWC/NTT
//               datapath. After an accepted start it emits 2^k beats under a
//               valid/ready handshake. Beat j carries 2^RADIX lane addresses:
//               lane i = (bitrev_k(j) << RADIX) | i.
//
// Ports       : clk        rising-edge clock
//               rst        asynchronous active-high reset
//               start      sequence request, sampled only in IDLE
//               k_cfg      depth k, sampled together with start
//               abort      synchronous cancel back to IDLE
//               out_ready  consumer accepts the current beat
//               out_valid  order_o holds a valid beat
//               order_o    packed lane addresses, lane i at [i*D_WIDTH +: D_WIDTH]
//               out_last   current beat is index 2^k-1
//               busy       block is not IDLE
//               done       one-cycle pulse after the last beat is accepted
//               cfg_err    one-cycle pulse when start is rejected (k_cfg > K_MAX)
//               l_out      k of the current or most recent sequence
//
// Revision    : 1.0  initial release
// ============================================================================
module agu_radix_param #(
    parameter int D_WIDTH = 16,
    parameter int RADIX   = 1,
    parameter int K_MAX   = 10,
    parameter int KW      = $clog2(K_MAX + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [KW-1:0]                    k_cfg,
    input  logic                             abort,
    input  logic                             out_ready,
    output logic                             out_valid,
    output logic [(2**RADIX)*D_WIDTH-1:0]    order_o,
    output logic                             out_last,
    output logic                             busy,
    output logic                             done,
    output logic                             cfg_err,
    output logic [KW-1:0]                    l_out
);

    localparam int c_LANES = 2**RADIX;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;

    localparam logic [KW-1:0] c_K_MAX = KW'(K_MAX);
    localparam logic [K_MAX:0] c_ONE  = {{K_MAX{1'b0}}, 1'b1};

    generate
        if (RADIX + K_MAX > D_WIDTH) begin : g_param_check
            $error("agu_radix_param: RADIX + K_MAX must not exceed D_WIDTH");
        end
    endgenerate

    logic [1:0]                   state_q,   state_d;
    logic [K_MAX:0]               j_q,       j_d;
    logic [KW-1:0]                k_q,       k_d;
    logic                         valid_q,   valid_d;
    logic                         last_q,    last_d;
    logic [c_LANES*D_WIDTH-1:0]   order_q,   order_d;
    logic                         done_q,    done_d;
    logic                         cfg_err_q, cfg_err_d;

    logic [K_MAX-1:0]             w_rev_full;
    logic [K_MAX-1:0]             w_rev;
    logic [KW-1:0]                w_shift;
    logic [K_MAX:0]               w_last_idx;
    logic                         w_is_last;
    logic [c_LANES*D_WIDTH-1:0]   w_order;

    // Reverse over the full K_MAX width, then drop the unused low-order
    // positions so the result is the k-bit reversal of j.
    always_comb begin
        w_rev_full = '0;
        for (int b = 0; b < K_MAX; b++) begin
            w_rev_full[b] = j_q[K_MAX-1-b];
        end
    end

    assign w_shift    = c_K_MAX - k_q;
    assign w_rev      = w_rev_full >> w_shift;
    assign w_last_idx = (c_ONE << k_q) - c_ONE;
    assign w_is_last  = (j_q == w_last_idx);

    generate
        for (genvar i = 0; i < c_LANES; i++) begin : g_lane
            localparam logic [RADIX-1:0] c_LANE_IDX = RADIX'(i);
            assign w_order[i*D_WIDTH +: D_WIDTH] = D_WIDTH'({w_rev, c_LANE_IDX});
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        j_d       = j_q;
        k_d       = k_q;
        valid_d   = valid_q;
        last_d    = last_q;
        order_d   = order_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;

        if (abort) begin
            state_d = c_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            j_d     = '0;
        end else begin
            case (state_q)
                c_IDLE: begin
                    if (start) begin
                        if (k_cfg <= c_K_MAX) begin
                            k_d     = k_cfg;
                            j_d     = '0;
                            state_d = c_RUN;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                c_RUN: begin
                    // Output register is free when empty or being drained.
                    if (!valid_q || out_ready) begin
                        order_d = w_order;
                        valid_d = 1'b1;
                        last_d  = w_is_last;
                        j_d     = j_q + c_ONE;
                        if (w_is_last) begin
                            state_d = c_FLUSH;
                        end
                    end
                end
                c_FLUSH: begin
                    if (valid_q && out_ready) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = c_IDLE;
                    end
                end
                default: begin
                    state_d = c_IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    j_d     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= c_IDLE;
            j_q       <= '0;
            k_q       <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            order_q   <= '0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            j_q       <= j_d;
            k_q       <= k_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            order_q   <= order_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign out_valid = valid_q;
    assign order_o   = order_q;
    assign out_last  = last_q;
    assign busy      = (state_q != c_IDLE);
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;
    assign l_out     = k_q;

endmodule
`default_nettype wire

// File: tb/tb_agu_radix_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_agu_radix_param
// Description : Bench for agu_radix_param. Two instances (RADIX=1 and
//               RADIX=2) share all inputs; a transaction-level model checks
//               both every cycle, and directed literals pin the model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_agu_radix_param;

    localparam int c_DW   = 16;
    localparam int c_KMAX = 10;
    localparam int c_KW   = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [c_KW-1:0] k_cfg = '0;
    logic            abort = 1'b0;
    logic            out_ready = 1'b1;

    logic            valid1, last1, busy1, done1, cerr1;
    logic [31:0]     order1;
    logic [c_KW-1:0] l1;
    logic            valid2, last2, busy2, done2, cerr2;
    logic [63:0]     order2;
    logic [c_KW-1:0] l2;

    int errors = 0;
    int checks = 0;

    agu_radix_param #(.D_WIDTH(c_DW), .RADIX(1), .K_MAX(c_KMAX), .KW(c_KW)) dut1 (
        .clk(clk), .rst(rst), .start(start), .k_cfg(k_cfg), .abort(abort),
        .out_ready(out_ready), .out_valid(valid1), .order_o(order1),
        .out_last(last1), .busy(busy1), .done(done1), .cfg_err(cerr1), .l_out(l1)
    );

    agu_radix_param #(.D_WIDTH(c_DW), .RADIX(2), .K_MAX(c_KMAX), .KW(c_KW)) dut2 (
        .clk(clk), .rst(rst), .start(start), .k_cfg(k_cfg), .abort(abort),
        .out_ready(out_ready), .out_valid(valid2), .order_o(order2),
        .out_last(last2), .busy(busy2), .done(done2), .cfg_err(cerr2), .l_out(l2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Beat contents from first principles: reverse k bits of j arithmetically.
    function automatic logic [63:0] exp_order(input int radix, input int j, input int k);
        int rev;
        logic [63:0] r;
        rev = 0;
        for (int b = 0; b < k; b++) rev = rev * 2 + ((j >> b) & 1);
        r = '0;
        for (int i = 0; i < (1 << radix); i++) r[i*16 +: 16] = 16'(rev * (1 << radix) + i);
        return r;
    endfunction

    // ---------------- model state ----------------
    bit          m_busy = 0;
    int          m_k = 0;
    int          m_since = 0;
    int          m_acc = 0;
    bit          m_pend_done = 0;
    bit          m_pend_cfg = 0;
    bit          m_prev_stall = 0;
    logic [31:0] m_prev_order1 = '0;
    int          done_cnt = 0;
    int          q1[$];
    logic [63:0] q2[$];

    always @(negedge clk) begin
        bit busy_now, exp_valid;
        if (rst) begin
            m_busy = 0; m_k = 0; m_since = 0; m_acc = 0;
            m_pend_done = 0; m_pend_cfg = 0; m_prev_stall = 0;
        end else begin
            exp_valid = m_busy && (m_since >= 1);
            chk("busy",      64'(busy1),  64'(m_busy));
            chk("done",      64'(done1),  64'(m_pend_done));
            chk("cfg_err",   64'(cerr1),  64'(m_pend_cfg));
            chk("l_out",     64'(l1),     64'(m_k));
            chk("out_valid", 64'(valid1), 64'(exp_valid));
            chk("r2_ctrl", {59'd0, valid2, busy2, done2, cerr2, last2},
                           {59'd0, valid1, busy1, done1, cerr1, last1});
            if (exp_valid) begin
                chk("order_r1", 64'(order1), exp_order(1, m_acc, m_k) & 64'hFFFF_FFFF);
                chk("order_r2", order2, exp_order(2, m_acc, m_k));
                chk("out_last", 64'(last1), 64'(m_acc == (1 << m_k) - 1));
            end
            if (m_prev_stall) chk("stall_stable", 64'(order1), 64'(m_prev_order1));
            if (done1) done_cnt++;

            busy_now      = m_busy;
            m_pend_done   = 0;
            m_pend_cfg    = 0;
            m_prev_stall  = valid1 && !out_ready && !abort;
            m_prev_order1 = order1;
            if (abort) begin
                m_busy = 0; m_acc = 0; m_since = 0;
            end else begin
                if (busy_now) m_since++;
                if (exp_valid && out_ready) begin
                    q1.push_back(int'(order1[15:0]));
                    q2.push_back(order2);
                    m_acc++;
                    if (m_acc == (1 << m_k)) begin
                        m_busy = 0;
                        m_pend_done = 1;
                    end
                end
                if (!busy_now && start) begin
                    if (int'(k_cfg) <= c_KMAX) begin
                        m_k = int'(k_cfg); m_busy = 1; m_acc = 0; m_since = 0;
                    end else begin
                        m_pend_cfg = 1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int k);
        start = 1'b1;
        k_cfg = c_KW'(k);
        tick();
        start = 1'b0;
    endtask

    // pattern 0: ready held high; pattern 1: ready 1,0,0,1 repeating
    task automatic run_until_done(input int budget, input int pattern);
        bit seen;
        seen = 0;
        for (int c = 0; c < budget; c++) begin
            out_ready = (pattern == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
            tick();
            if (done1) begin
                seen = 1;
                break;
            end
        end
        out_ready = 1'b1;
        chk("done_within_budget", 64'(seen), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_r1"}, {order1, 20'd0, valid1, last1, busy1, done1, cerr1, l1, 3'd0}, 64'd0);
        chk({tag, "_r2"}, order2, 64'd0);
        chk({tag, "_r2c"}, {55'd0, valid2, last2, busy2, done2, cerr2, l2}, 64'd0);
    endtask

    int e3[8]   = '{0, 8, 4, 12, 2, 10, 6, 14};
    int e4[16]  = '{0, 16, 8, 24, 4, 20, 12, 28, 2, 18, 10, 26, 6, 22, 14, 30};
    int e2[4]   = '{0, 4, 2, 6};
    logic [63:0] e2r2[4] = '{64'h0003_0002_0001_0000, 64'h000B_000A_0009_0008,
                             64'h0007_0006_0005_0004, 64'h000F_000E_000D_000C};

    initial begin
        int dc;
        // Reset state
        repeat (2) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // k=3, ready high: 8 beats in bit-reverse order
        q1.delete();
        dc = done_cnt;
        do_start(3);
        run_until_done(40, 0);
        chk("k3_beats", 64'(q1.size()), 64'd8);
        for (int i = 0; i < 8 && i < q1.size(); i++) chk("k3_lane0", 64'(q1[i]), 64'(e3[i]));
        tick();
        chk("k3_done_count", 64'(done_cnt - dc), 64'd1);

        // k=0: single beat {0,1} with last
        q1.delete();
        do_start(0);
        tick();
        chk("k0_valid", 64'(valid1), 64'd1);
        chk("k0_order", 64'(order1), 64'h0000_0000_0001_0000);
        chk("k0_last",  64'(last1), 64'd1);
        tick();
        chk("k0_done",  64'(done1), 64'd1);
        chk("k0_busy",  64'(busy1), 64'd0);
        tick();

        // k=4 with ready toggling
        q1.delete();
        do_start(4);
        run_until_done(200, 1);
        chk("k4_beats", 64'(q1.size()), 64'd16);
        for (int i = 0; i < 16 && i < q1.size(); i++) chk("k4_lane0", 64'(q1[i]), 64'(e4[i]));
        tick();

        // k=11 rejected
        do_start(11);
        chk("k11_cfg_err", 64'(cerr1), 64'd1);
        chk("k11_busy",    64'(busy1), 64'd0);
        tick();
        chk("k11_valid",   64'(valid1), 64'd0);
        chk("k11_cfg_once", 64'(cerr1), 64'd0);

        // abort after 5 accepted beats of k=4
        q1.delete();
        dc = done_cnt;
        do_start(4);
        for (int c = 0; c < 40; c++) begin
            tick();
            if (q1.size() >= 5) break;
        end
        chk("abort_pre_beats", 64'(q1.size()), 64'd5);
        abort = 1'b1;
        out_ready = 1'b0;
        tick();
        abort = 1'b0;
        out_ready = 1'b1;
        chk("abort_valid", 64'(valid1), 64'd0);
        chk("abort_busy",  64'(busy1), 64'd0);
        repeat (3) tick();
        chk("abort_no_done", 64'(done_cnt - dc), 64'd0);
        q1.delete();
        do_start(2);
        run_until_done(30, 0);
        chk("k2_beats", 64'(q1.size()), 64'd4);
        for (int i = 0; i < 4 && i < q1.size(); i++) chk("k2_lane0", 64'(q1[i]), 64'(e2[i]));
        tick();

        // asynchronous reset mid-RUN
        do_start(4);
        repeat (3) tick();
        chk("pre_rst_valid", 64'(valid1), 64'd1);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        tick();
        rst = 1'b0;
        tick();

        // RADIX=2 instance, k=2
        q2.delete();
        do_start(2);
        run_until_done(30, 0);
        chk("r2_beats", 64'(q2.size()), 64'd4);
        for (int i = 0; i < 4 && i < q2.size(); i++) chk("r2_k2_beat", q2[i], e2r2[i]);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/agu_radix_param.md
# agu_radix_param

Parametrised address generation unit for the NWC/NTT datapath, successor to the fixed-radix stage-2 AGU. After a start pulse it emits 2^k beats. Beat j carries 2^RADIX lane addresses: the k-bit bit-reverse of j, shifted left by RADIX, plus the lane index. The transform depth k is set at run time, output is governed by a valid/ready handshake, and completion is signalled by a last flag plus a done pulse. It sits between the stage controller and the memory bank address mapper.

## Interface
- D_WIDTH, 16: width of each lane address.
- RADIX, 1: log2 of lane count; LANES = 2^RADIX.
- K_MAX, 10: maximum runtime depth k. RADIX + K_MAX <= D_WIDTH is required; elaboration-time check.
- KW, $clog2(K_MAX+1): width of k_cfg.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request a sequence; sampled only in IDLE.
- k_cfg  in  KW  depth k for the requested sequence; sampled with start.
- abort  in  1  synchronous cancel; returns the block to IDLE.
- out_ready  in  1  consumer accepts the current beat.
- out_valid  out  1  order_o holds a valid beat.
- order_o  out  LANES*D_WIDTH  lane i occupies bits [i*D_WIDTH +: D_WIDTH].
- out_last  out  1  current beat is index 2^k-1.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse after the last beat is accepted.
- cfg_err  out  1  one-cycle pulse when start is rejected because k_cfg > K_MAX.
- l_out  out  KW  latched k of the current or most recent sequence.

## Operation
- States: IDLE, RUN, FLUSH.
- **IDLE**
  - start=1 and k_cfg <= K_MAX: latch k, j <= 0, go to RUN.
  - start=1 and k_cfg > K_MAX: cfg_err pulse, stay in IDLE.
  - start=0: no action.
- **RUN**
  - Load condition: !out_valid || out_ready.
  - On each load: register the beat for index j, out_valid <= 1, j <= j+1.
  - Loading index 2^k-1: set out_last, go to FLUSH.
- **FLUSH**
  - out_valid && out_ready: out_valid <= 0, out_last <= 0, done <= 1, go to IDLE.
- **Beat contents**
  - rev = bit-reverse of j over k bits: reverse over K_MAX bits, then shift right by K_MAX-k.
  - lane i = (rev << RADIX) | i, zero-extended to D_WIDTH.
- Counter j is K_MAX+1 bits wide, so it cannot wrap for k = K_MAX.
- k = 0: one beat. rev = 0, lane i = i, out_last = 1.
- order_o, out_last and out_valid are registered. They hold stable while out_valid && !out_ready.
- start in RUN or FLUSH is ignored. k_cfg is ignored outside an accepted start.
- **abort** (any state)
  - Next cycle: state IDLE, out_valid = 0, out_last = 0, j = 0.
  - No done pulse.
  - abort takes priority over start in the same cycle.
- l_out updates only on an accepted start.

## Timing
- Reset values: out_valid 0, order_o 0, out_last 0, busy 0, done 0, cfg_err 0, l_out 0. State IDLE, j 0.
- Start accepted at edge e0: busy=1 after e0; first out_valid=1 after e1.
- With out_ready held high: one beat per cycle, last beat after edge e(2^k).
  - done high for exactly one cycle after the edge that accepts the last beat.
  - busy falls together with done rising.
- A new start is accepted in the cycle done is high, since the block is in IDLE by then.
- Backpressure: no beat is lost or duplicated. Beat order is strictly j ascending.
- Reset asserted mid-sequence: all outputs return to their reset values immediately (asynchronous).

## Test plan
- RADIX=1, K_MAX=10, k_cfg=3, out_ready=1 -> 8 beats.
  - Lane0 sequence: 0,8,4,12,2,10,6,14; lane1 = lane0+1.
  - out_last on beat 8; done one cycle after beat 8.
- k_cfg=0 -> single beat, order_o lanes {0,1}, out_last=1, then done.
- k_cfg=4, out_ready toggling 1,0,0,1,... -> exactly 16 beats in bit-reverse order; order_o stable during stalls.
- k_cfg=11 with K_MAX=10 -> cfg_err pulse, busy stays 0, no out_valid.
- abort after 5 accepted beats of k=4 -> out_valid 0 next cycle, no done.
  - A following start with k=2 yields lane0 sequence 0,4,2,6.
- rst asserted mid-RUN -> all outputs 0 without a clock edge.
  - RADIX=2 rerun with k=2 yields lanes {0..3},{8..11},{4..7},{12..15}.
